// File: rtl/vec_operand_stager_pkg.sv
// Shared definitions for the vector operand stager: lane width, FSM encoding
// and the helpers that size the beat counter.
package mpu_vec_pkg;

  localparam int LANE_W = 8;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_D = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;

  function automatic int beats_f(input int num_bits, input int bus_w);
    return num_bits / bus_w;
  endfunction

  // A single-beat vector still needs a 1-bit counter to keep ports legal.
  function automatic int cnt_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vec_operand_stager_beat_assembler.sv
// Collects narrow bus beats into one full-width operand register; beat index
// selects the slice, beat 0 lands in the LSBs.
module vec_beat_assembler #(
  parameter int NUM_BITS = 512,
  parameter int BUS_W    = 64,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [BUS_W-1:0]    i_data,
  output logic [NUM_BITS-1:0] o_vec
);

  logic [NUM_BITS-1:0] r_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec <= '0;
    end else if (i_we) begin
      r_vec[BUS_W*i_idx +: BUS_W] <= i_data;
    end
  end

  assign o_vec = r_vec;

endmodule

// File: rtl/vec_operand_stager.sv
// Stages operand A then operand D from a beat stream and presents the pair to
// the lane-wise adder, dropping frames whose in_last marker is misplaced.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   LOAD_A    | accepting beats of operand A
//   LOAD_D    | accepting beats of operand D
//   ISSUE     | aa/dd frozen, op_valid high until op_ready
module vec_operand_stager
  import mpu_vec_pkg::*;
#(
  parameter int NUM_BITS = 512,
  parameter int BUS_W    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BUS_W-1:0]    in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] aa,
  output logic [NUM_BITS-1:0] dd,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                frame_err
);

  localparam int BEATS = beats_f(NUM_BITS, BUS_W);
  localparam int CNT_W = cnt_w_f(BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_frame_err;

  logic w_accept;
  logic w_last_beat;
  logic w_we_a;
  logic w_we_d;

  assign in_ready    = !rst && (r_state != ST_ISSUE);
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (r_beat_cnt == LAST_IDX);
  assign w_we_a      = w_accept && (r_state == ST_LOAD_A);
  assign w_we_d      = w_accept && (r_state == ST_LOAD_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD_A;
      r_beat_cnt  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_LOAD_A: begin
          if (w_accept) begin
            if (in_last) begin
              r_frame_err <= 1'b1;
              r_beat_cnt  <= '0;
            end else if (w_last_beat) begin
              r_state    <= ST_LOAD_D;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_LOAD_D: begin
          if (w_accept) begin
            if (w_last_beat) begin
              // Only a correctly marked final beat reaches ISSUE.
              r_beat_cnt  <= '0;
              r_state     <= in_last ? ST_ISSUE : ST_LOAD_A;
              r_frame_err <= !in_last;
            end else if (in_last) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_LOAD_A;
              r_beat_cnt  <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (op_ready) begin
            r_state <= ST_LOAD_A;
          end
        end
        default: begin
          r_state    <= ST_LOAD_A;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  assign op_valid  = (r_state == ST_ISSUE);
  assign frame_err = r_frame_err;

  vec_beat_assembler #(
    .NUM_BITS (NUM_BITS),
    .BUS_W    (BUS_W),
    .IDX_W    (CNT_W)
  ) u_asm_a (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we_a),
    .i_idx  (r_beat_cnt),
    .i_data (in_data),
    .o_vec  (aa)
  );

  vec_beat_assembler #(
    .NUM_BITS (NUM_BITS),
    .BUS_W    (BUS_W),
    .IDX_W    (CNT_W)
  ) u_asm_d (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we_d),
    .i_idx  (r_beat_cnt),
    .i_data (in_data),
    .o_vec  (dd)
  );

endmodule

// File: tb/tb_vec_operand_stager.sv
// Directed bench for vec_operand_stager with an attached lane-wise adder model.
module tb_vec_operand_stager;

  localparam int NUM_BITS = 512;
  localparam int BUS_W    = 64;
  localparam int BEATS    = NUM_BITS / BUS_W;

  logic                clk = 1'b0;
  logic                rst;
  logic [BUS_W-1:0]    in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [NUM_BITS-1:0] aa;
  logic [NUM_BITS-1:0] dd;
  logic                op_valid;
  logic                op_ready;
  logic                frame_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [NUM_BITS-1:0] exp_aa;
  logic [NUM_BITS-1:0] exp_dd;
  logic [NUM_BITS-1:0] exp_sum;
  logic [NUM_BITS-1:0] hold_aa;
  logic [NUM_BITS-1:0] hold_dd;

  vec_operand_stager #(
    .NUM_BITS (NUM_BITS),
    .BUS_W    (BUS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .aa        (aa),
    .dd        (dd),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_BITS-1:0] lane_add(input logic [NUM_BITS-1:0] a,
                                                   input logic [NUM_BITS-1:0] d);
    logic [NUM_BITS-1:0] s;
    for (int i = 0; i < NUM_BITS / 8; i++) s[8*i +: 8] = a[8*i +: 8] + d[8*i +: 8];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [NUM_BITS-1:0] obs,
                     input logic [NUM_BITS-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [BUS_W-1:0] data, input logic last);
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends A beats of a_byte then D beats {8{k}}; in_last on beat index last_pos.
  task automatic send_frame(input logic [7:0] a_byte, input int last_pos,
                            input int max_bubble);
    logic [7:0] kb;
    for (int k = 0; k < 2*BEATS; k++) begin
      for (int b = $urandom_range(max_bubble, 0); b > 0; b--) tick();
      if (k == 2*BEATS-1) chk("no_early_valid", {511'd0, op_valid}, 512'd0);
      kb = (k - BEATS) & 8'hff;
      if (k < BEATS) send_beat({8{a_byte}}, k == last_pos);
      else           send_beat({8{kb}}, k == last_pos);
    end
  endtask

  task automatic build_exp(input logic [7:0] a_byte);
    logic [7:0] kb;
    exp_aa = {(NUM_BITS/8){a_byte}};
    for (int k = 0; k < BEATS; k++) begin
      kb = k[7:0];
      exp_dd[BUS_W*k +: BUS_W] = {8{kb}};
      for (int l = 0; l < 8; l++) exp_sum[BUS_W*k + 8*l +: 8] = a_byte + kb;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    op_ready = 1'b0;

    // 1: reset
    tick();
    tick();
    chk("rst_in_ready", {511'd0, in_ready}, 512'd0);
    chk("rst_op_valid", {511'd0, op_valid}, 512'd0);
    chk("rst_aa", aa, 512'd0);
    chk("rst_dd", dd, 512'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {511'd0, in_ready}, 512'd1);

    // 2: back-to-back frame
    build_exp(8'h01);
    send_frame(8'h01, 2*BEATS-1, 0);
    chk("b2b_op_valid", {511'd0, op_valid}, 512'd1);
    chk("b2b_in_ready", {511'd0, in_ready}, 512'd0);
    chk("b2b_aa", aa, exp_aa);
    chk("b2b_dd", dd, exp_dd);
    chk("b2b_sum", lane_add(aa, dd), exp_sum);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("b2b_release", {511'd0, op_valid}, 512'd0);
    chk("b2b_aa_kept", aa, exp_aa);

    // 3: backpressure with in_valid held high
    build_exp(8'h03);
    send_frame(8'h03, 2*BEATS-1, 0);
    hold_aa  = aa;
    hold_dd  = dd;
    in_valid = 1'b1;
    in_data  = {8{8'hee}};
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_op_valid", {511'd0, op_valid}, 512'd1);
      chk("bp_in_ready", {511'd0, in_ready}, 512'd0);
      chk("bp_aa", aa, exp_aa);
      chk("bp_dd", dd, exp_dd);
    end
    chk("bp_sum", lane_add(aa, dd), exp_sum);
    op_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    op_ready = 1'b0;
    chk("bp_release", {511'd0, op_valid}, 512'd0);

    // 4: bubbles; a full clean frame must issue exactly after 16 accepted beats
    build_exp(8'h01);
    send_frame(8'h01, 2*BEATS-1, 2);
    chk("bub_op_valid", {511'd0, op_valid}, 512'd1);
    chk("bub_aa", aa, exp_aa);
    chk("bub_dd", dd, exp_dd);
    chk("bub_sum", lane_add(aa, dd), exp_sum);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // 5: early in_last on A beat 3
    for (int k = 0; k < 4; k++) send_beat({8{8'h55}}, k == 3);
    chk("early_err", {511'd0, frame_err}, 512'd1);
    chk("early_no_valid", {511'd0, op_valid}, 512'd0);
    tick();
    chk("early_err_pulse", {511'd0, frame_err}, 512'd0);
    build_exp(8'h02);
    send_frame(8'h02, 2*BEATS-1, 0);
    chk("early_next_valid", {511'd0, op_valid}, 512'd1);
    chk("early_next_aa", aa, exp_aa);
    chk("early_next_sum", lane_add(aa, dd), exp_sum);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // 6: missing in_last on final D beat, then reset during ISSUE
    send_frame(8'h07, -1, 0);
    chk("miss_err", {511'd0, frame_err}, 512'd1);
    chk("miss_no_valid", {511'd0, op_valid}, 512'd0);
    tick();
    chk("miss_err_pulse", {511'd0, frame_err}, 512'd0);
    chk("miss_in_ready", {511'd0, in_ready}, 512'd1);
    build_exp(8'h01);
    send_frame(8'h01, 2*BEATS-1, 0);
    chk("pre_rst_valid", {511'd0, op_valid}, 512'd1);
    rst = 1'b1;
    #1;
    chk("rst_hi_in_ready", {511'd0, in_ready}, 512'd0);
    tick();
    chk("issue_rst_valid", {511'd0, op_valid}, 512'd0);
    chk("issue_rst_aa", aa, 512'd0);
    chk("issue_rst_dd", dd, 512'd0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
